// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the fetch PC sequencer.
// Build option: define PC_SEQUENCER_RAS_EN to include the hardware return-address stack.
package pc_seq_pkg;

  // PC-source select from the PC control unit; 3'b101..3'b111 fall back to sequential.
  typedef enum logic [2:0] {
    PC_PLUS4   = 3'b000,
    PC_JUMP    = 3'b001,
    PC_BRANCH  = 3'b010,
    PC_CALLRS1 = 3'b011,
    PC_RET     = 3'b100
  } pc_src_e;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    FLUSH
  } seq_state_e;

  localparam int unsigned PC_INCR = 4;

  // Word-align a fetch address by clearing the byte-offset bits.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_sequencer_ras.sv
// Return-address stack: circular write pointer plus a saturating occupancy count.
// When full, a push overwrites the oldest entry. Push and pop together replace the top.
// Overflow/underflow flags are sticky until reset.
module ras_stack #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] top_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             ovf_o,
  output logic             unf_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW-1:0]    top_idx;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             do_pop;
  logic             replace;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign top_idx = ptr_q - PW'(1);
  assign top_o   = mem_q[top_idx];
  assign ovf_o   = ovf_q;
  assign unf_o   = unf_q;

  assign do_pop  = pop_i && !empty_o;
  // Popping an empty stack yields no entry, so a simultaneous push is an ordinary push.
  assign replace = push_i && do_pop;

  // Next pointer, count and sticky error flags.
  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (pop_i && empty_o) begin
      unf_d = 1'b1;
    end
    if (replace) begin
      ptr_d = ptr_q;
      cnt_d = cnt_q;
    end else if (push_i) begin
      ptr_d = ptr_q + PW'(1);
      if (full_o) begin
        ovf_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else if (do_pop) begin
      ptr_d = top_idx;
      cnt_d = cnt_q - CW'(1);
    end
  end

  // Control state with synchronous reset; dropping the count discards the contents.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Entry storage; a replace writes the current top, a push writes the next slot.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (replace) begin
        mem_q[top_idx] <= data_i;
      end else if (push_i) begin
        mem_q[ptr_q] <= data_i;
      end
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: owns the fetch PC, applies redirects with a fixed bubble window,
// and qualifies fetch with o_if_valid / o_flush.
// Build option: PC_SEQUENCER_RAS_EN instantiates ras_stack so Ret targets come from hardware;
// without it Ret uses i_ret_target, SIG_Call is ignored and the RAS flags read 0.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned       ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter int unsigned       RAS_DEPTH   = 4,
  parameter int unsigned       KILL_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        PcSource,
  input  logic              SIG_Kill,
  input  logic              SIG_Call,
  input  logic              SIG_Stall,
  input  logic [ADDR_W-1:0] i_jump_target,
  input  logic [ADDR_W-1:0] i_branch_target,
  input  logic [ADDR_W-1:0] i_rs1_target,
  input  logic [ADDR_W-1:0] i_ret_target,
  input  logic [ADDR_W-1:0] i_link_addr,
  output logic [ADDR_W-1:0] o_pc,
  output logic              o_if_valid,
  output logic              o_flush,
  output logic              o_misalign,
  output logic              o_ras_ovf,
  output logic              o_ras_unf
);

  localparam logic [1:0] KILL_LD = 2'(KILL_CYCLES);

  seq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              mis_q, mis_d;

  logic              redirect;
  logic [ADDR_W-1:0] sel_target;
  logic [ADDR_W-1:0] ret_target;

`ifdef PC_SEQUENCER_RAS_EN
  logic [ADDR_W-1:0] ras_top;
  logic              ras_full;
  logic              ras_empty;
  logic              ret_pop;
  logic              unused_ok;

  // Only a taken Ret consumes a stack entry, whether or not fetch is stalled.
  assign ret_pop    = SIG_Kill && (PcSource == PC_RET);
  assign ret_target = ras_empty ? RESET_PC : ras_top;

  ras_stack #(
    .DEPTH (RAS_DEPTH),
    .WIDTH (ADDR_W)
  ) u_ras (
    .clk_i   (clk),
    .rst_i   (reset),
    .push_i  (SIG_Call),
    .pop_i   (ret_pop),
    .data_i  (i_link_addr),
    .top_o   (ras_top),
    .full_o  (ras_full),
    .empty_o (ras_empty),
    .ovf_o   (o_ras_ovf),
    .unf_o   (o_ras_unf)
  );

  assign unused_ok = ^{ras_full, i_ret_target};
`else
  logic unused_ok;

  assign ret_target = i_ret_target;
  assign o_ras_ovf  = 1'b0;
  assign o_ras_unf  = 1'b0;
  assign unused_ok  = ^{SIG_Call, i_link_addr};
`endif

  // Redirect decode: only a killed cycle with a non-sequential source redirects.
  always_comb begin
    redirect   = 1'b0;
    sel_target = '0;
    if (SIG_Kill) begin
      case (PcSource)
        PC_JUMP: begin
          redirect   = 1'b1;
          sel_target = i_jump_target;
        end
        PC_BRANCH: begin
          redirect   = 1'b1;
          sel_target = i_branch_target;
        end
        PC_CALLRS1: begin
          redirect   = 1'b1;
          sel_target = i_rs1_target;
        end
        PC_RET: begin
          redirect   = 1'b1;
          sel_target = ret_target;
        end
        default: begin
          redirect   = 1'b0;
          sel_target = '0;
        end
      endcase
    end
  end

  // Next state: redirect beats stall; PC holds during BOOT and bubbles so the
  // target instruction is fetched again once the window closes.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    mis_d   = redirect && (sel_target[1:0] != 2'b00);
    if (redirect) begin
      pc_d    = {sel_target[ADDR_W-1:2], 2'b00};
      state_d = FLUSH;
      cnt_d   = KILL_LD;
    end else begin
      case (state_q)
        BOOT: begin
          state_d = RUN;
        end
        RUN: begin
          if (!SIG_Stall) begin
            pc_d = pc_q + ADDR_W'(PC_INCR);
          end
        end
        FLUSH: begin
          cnt_d = cnt_q - 2'd1;
          if (cnt_q <= 2'd1) begin
            cnt_d   = '0;
            state_d = RUN;
          end
        end
        default: begin
          state_d = BOOT;
        end
      endcase
    end
  end

  // Sequencer registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      mis_q   <= mis_d;
    end
  end

  assign o_pc       = pc_q;
  assign o_misalign = mis_q;
  assign o_if_valid = (state_q == RUN) && !SIG_Stall;
  assign o_flush    = (state_q == FLUSH) || redirect;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: each driven cycle pushes the expected outputs,
// which the negedge monitor pops and compares. Covers PC_SEQUENCER_RAS_EN when defined.
module tb_pc_sequencer;
  import pc_seq_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  PcSource = 3'b000;
  logic        SIG_Kill = 1'b0;
  logic        SIG_Call = 1'b0;
  logic        SIG_Stall = 1'b0;
  logic [31:0] i_jump_target = 32'h0000_1000;
  logic [31:0] i_branch_target = 32'h0000_2000;
  logic [31:0] i_rs1_target = 32'h0000_3000;
  logic [31:0] i_ret_target = 32'h0000_4000;
  logic [31:0] i_link_addr = 32'h0;
  logic [31:0] o_pc;
  logic        o_if_valid, o_flush, o_misalign, o_ras_ovf, o_ras_unf;

  typedef struct packed {
    logic [31:0] pc;
    logic        v;
    logic        f;
    logic        m;
    logic        ovf;
    logic        unf;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    checks = 0;
  int    failures = 0;
  logic  exp_ovf = 1'b0;
  logic  exp_unf = 1'b0;
  logic [31:0] mid_pc;

  pc_sequencer #(
    .ADDR_W      (32),
    .RESET_PC    (32'h0000_0000),
    .RAS_DEPTH   (4),
    .KILL_CYCLES (1)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .PcSource        (PcSource),
    .SIG_Kill        (SIG_Kill),
    .SIG_Call        (SIG_Call),
    .SIG_Stall       (SIG_Stall),
    .i_jump_target   (i_jump_target),
    .i_branch_target (i_branch_target),
    .i_rs1_target    (i_rs1_target),
    .i_ret_target    (i_ret_target),
    .i_link_addr     (i_link_addr),
    .o_pc            (o_pc),
    .o_if_valid      (o_if_valid),
    .o_flush         (o_flush),
    .o_misalign      (o_misalign),
    .o_ras_ovf       (o_ras_ovf),
    .o_ras_unf       (o_ras_unf)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One cycle of stimulus; the target argument lands on the input selected by src.
  task automatic drv(input string tag, input logic rst, input logic [2:0] src, input logic kill,
                     input logic [31:0] tgt, input logic call, input logic [31:0] link,
                     input logic stall, input logic [31:0] e_pc, input logic e_v,
                     input logic e_f, input logic e_m);
    @(posedge clk);
    #1;
    reset     = rst;
    PcSource  = src;
    SIG_Kill  = kill;
    SIG_Call  = call;
    SIG_Stall = stall;
    if (call) i_link_addr = link;
    case (src)
      3'd1: i_jump_target = tgt;
      3'd2: i_branch_target = tgt;
      3'd3: i_rs1_target = tgt;
      3'd4: i_ret_target = tgt;
      default: ;
    endcase
    exp_q.push_back('{pc: e_pc, v: e_v, f: e_f, m: e_m, ovf: exp_ovf, unf: exp_unf});
    tag_q.push_back(tag);
  endtask

  task automatic idle(input string tag, input logic [31:0] e_pc, input logic e_v, input logic e_f);
    drv(tag, 1'b0, PC_PLUS4, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, e_pc, e_v, e_f, 1'b0);
  endtask

  // Monitor: compare each cycle's outputs mid-cycle against the scoreboard.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t  e;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      chk_eq({t, ".pc"},  o_pc, e.pc);
      chk_eq({t, ".vld"}, 32'(o_if_valid), 32'(e.v));
      chk_eq({t, ".fl"},  32'(o_flush), 32'(e.f));
      chk_eq({t, ".mis"}, 32'(o_misalign), 32'(e.m));
      chk_eq({t, ".ovf"}, 32'(o_ras_ovf), 32'(e.ovf));
      chk_eq({t, ".unf"}, 32'(o_ras_unf), 32'(e.unf));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    drv("rst", 1'b1, PC_PLUS4, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    idle("boot", 32'h0, 1'b0, 1'b0);
    idle("run0", 32'h0, 1'b1, 1'b0);
    idle("run4", 32'h4, 1'b1, 1'b0);
    idle("run8", 32'h8, 1'b1, 1'b0);
    idle("runC", 32'hC, 1'b1, 1'b0);
    // Jump at 0x10 with one bubble.
    drv("jmp", 1'b0, PC_JUMP, 1'b1, 32'h200, 1'b0, 32'h0, 1'b0, 32'h10, 1'b1, 1'b1, 1'b0);
    idle("jmp_bub", 32'h200, 1'b0, 1'b1);
    idle("jmp_tgt", 32'h200, 1'b1, 1'b0);
    // Branch to 0x40, stall through the bubble and two more cycles, then branch while stalled.
    drv("br40", 1'b0, PC_BRANCH, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 32'h204, 1'b1, 1'b1, 1'b0);
    drv("stl_fl", 1'b0, PC_PLUS4, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h40, 1'b0, 1'b1, 1'b0);
    drv("stl1", 1'b0, PC_PLUS4, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h40, 1'b0, 1'b0, 1'b0);
    drv("stl2", 1'b0, PC_PLUS4, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h40, 1'b0, 1'b0, 1'b0);
    drv("stl_br", 1'b0, PC_BRANCH, 1'b1, 32'h80, 1'b0, 32'h0, 1'b1, 32'h40, 1'b0, 1'b1, 1'b0);
    idle("br_bub", 32'h80, 1'b0, 1'b1);
    idle("br_tgt", 32'h80, 1'b1, 1'b0);
    // Non-redirect encodings advance sequentially.
    drv("nokill", 1'b0, PC_JUMP, 1'b0, 32'h300, 1'b0, 32'h0, 1'b0, 32'h84, 1'b1, 1'b0, 1'b0);
    drv("src5", 1'b0, 3'b101, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 32'h88, 1'b1, 1'b0, 1'b0);
    // Misaligned target is aligned, with a one-cycle misalign pulse.
    drv("mis", 1'b0, PC_JUMP, 1'b1, 32'h203, 1'b0, 32'h0, 1'b0, 32'h8C, 1'b1, 1'b1, 1'b0);
    drv("mis_bub", 1'b0, PC_PLUS4, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h200, 1'b0, 1'b1, 1'b1);
    // Redirect during the bubble window takes the new target and restarts the window.
    drv("fl_j", 1'b0, PC_JUMP, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 32'h200, 1'b1, 1'b1, 1'b0);
    drv("fl_re", 1'b0, PC_BRANCH, 1'b1, 32'h180, 1'b0, 32'h0, 1'b0, 32'h100, 1'b0, 1'b1, 1'b0);
    idle("fl_bub", 32'h180, 1'b0, 1'b1);
    idle("fl_tgt", 32'h180, 1'b1, 1'b0);
`ifdef PC_SEQUENCER_RAS_EN
    drv("rs1", 1'b0, PC_CALLRS1, 1'b1, 32'h404, 1'b0, 32'h0, 1'b0, 32'h184, 1'b1, 1'b1, 1'b0);
    idle("ret_bub", 32'h404, 1'b0, 1'b1);
`else
    drv("ret_sw", 1'b0, PC_RET, 1'b1, 32'h404, 1'b0, 32'h0, 1'b0, 32'h184, 1'b1, 1'b1, 1'b0);
    drv("call_ign", 1'b0, PC_PLUS4, 1'b0, 32'h0, 1'b1, 32'h500, 1'b0, 32'h404, 1'b0, 1'b1, 1'b0);
`endif
    idle("ret_tgt", 32'h404, 1'b1, 1'b0);
    // Sequential wrap at the top of the address space.
    drv("wrap_j", 1'b0, PC_CALLRS1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0, 32'h408, 1'b1, 1'b1, 1'b0);
    idle("wrap_bub", 32'hFFFF_FFFC, 1'b0, 1'b1);
    idle("wrap_top", 32'hFFFF_FFFC, 1'b1, 1'b0);
    idle("wrap0", 32'h0, 1'b1, 1'b0);
`ifdef PC_SEQUENCER_RAS_EN
    drv("push104", 1'b0, PC_PLUS4, 1'b0, 32'h0, 1'b1, 32'h104, 1'b0, 32'h4, 1'b1, 1'b0, 1'b0);
    drv("push208", 1'b0, PC_PLUS4, 1'b0, 32'h0, 1'b1, 32'h208, 1'b0, 32'h8, 1'b1, 1'b0, 1'b0);
    drv("ret1", 1'b0, PC_RET, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 32'hC, 1'b1, 1'b1, 1'b0);
    idle("ret1_bub", 32'h208, 1'b0, 1'b1);
    drv("ret2", 1'b0, PC_RET, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 32'h208, 1'b1, 1'b1, 1'b0);
    drv("ret3", 1'b0, PC_RET, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 32'h104, 1'b0, 1'b1, 1'b0);
    exp_unf = 1'b1;
    idle("unf_bub", 32'h0, 1'b0, 1'b1);
    idle("unf_run", 32'h0, 1'b1, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      drv($sformatf("ovf_push%0d", i), 1'b0, PC_PLUS4, 1'b0, 32'h0, 1'b1, 32'(i * 16),
          1'b0, 32'(i * 4), 1'b1, 1'b0, 1'b0);
    end
    exp_ovf = 1'b1;
    drv("pop50", 1'b0, PC_RET, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 32'h18, 1'b1, 1'b1, 1'b0);
    drv("pop40", 1'b0, PC_RET, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 32'h50, 1'b0, 1'b1, 1'b0);
    drv("pop30", 1'b0, PC_RET, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 32'h40, 1'b0, 1'b1, 1'b0);
    drv("pop20", 1'b0, PC_RET, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 32'h30, 1'b0, 1'b1, 1'b0);
    idle("pop_bub", 32'h20, 1'b0, 1'b1);
    idle("pop_run", 32'h20, 1'b1, 1'b0);
    drv("push700", 1'b0, PC_PLUS4, 1'b0, 32'h0, 1'b1, 32'h700, 1'b0, 32'h24, 1'b1, 1'b0, 1'b0);
    drv("repl", 1'b0, PC_RET, 1'b1, 32'h0, 1'b1, 32'h800, 1'b0, 32'h28, 1'b1, 1'b1, 1'b0);
    drv("pop800", 1'b0, PC_RET, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 32'h700, 1'b0, 1'b1, 1'b0);
    idle("r8_bub", 32'h800, 1'b0, 1'b1);
    idle("r8_run", 32'h800, 1'b1, 1'b0);
    mid_pc = 32'h804;
`else
    mid_pc = 32'h4;
`endif
    // Reset in the middle of a bubble window drops it and the sticky flags.
    drv("j600", 1'b0, PC_JUMP, 1'b1, 32'h600, 1'b0, 32'h0, 1'b0, mid_pc, 1'b1, 1'b1, 1'b0);
    drv("rst_mid", 1'b1, PC_PLUS4, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h600, 1'b0, 1'b1, 1'b0);
    exp_ovf = 1'b0;
    exp_unf = 1'b0;
    idle("rst_boot", 32'h0, 1'b0, 1'b0);
    idle("rst_run", 32'h0, 1'b1, 1'b0);

    @(negedge clk);
    #1;
    chk_eq("sb_drain", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
